// File: rtl/axis_write_addr.sv
// AXI write-address generator for a stream-to-memory writer.
// Takes a start byte address and a length in stream words. Splits the
// transfer into maximum-size AW bursts, tracks outstanding write responses,
// and pulses done when every burst has been acknowledged. Any non-OKAY
// response sets a sticky error flag.
module axis_write_addr #(
   parameter int CONFIG_AWIDTH  = 32,
   parameter int CONFIG_DWIDTH  = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int CONVERT_SHIFT  = 1,
   parameter int BYTE_SHIFT     = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CONFIG_AWIDTH-1:0]  cfg_address,
   input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
   output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
   output logic                      axi_awvalid,
   input  logic                      axi_awready,
   input  logic [1:0]                axi_bresp,
   input  logic                      axi_bvalid,
   output logic                      axi_bready,
   output logic                      done,
   output logic                      error
);

   // Outstanding bursts can never exceed total beats / minimum full burst.
   localparam int OUT_W   = CONFIG_DWIDTH - AXI_LEN_WIDTH - CONVERT_SHIFT + 1;
   // A burst length needs one extra bit to hold 2^AXI_LEN_WIDTH.
   localparam int BURST_W = AXI_LEN_WIDTH + 1;
   localparam logic [CONFIG_DWIDTH-1:0] MAX_BURST = CONFIG_DWIDTH'(1) << AXI_LEN_WIDTH;

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_CONFIG = 5'b00010,
      S_ADDR   = 5'b00100,
      S_WAIT   = 5'b01000,
      S_DONE   = 5'b10000
   } state_t;

   state_t                    state_reg;
   logic [AXI_ADDR_WIDTH-1:0] addr_reg;
   logic [CONFIG_DWIDTH-1:0]  beats_rem_reg;
   logic [BURST_W-1:0]        burst_reg;
   logic [BURST_W-1:0]        burst_next;
   logic [BURST_W-1:0]        awlen_next;
   logic [OUT_W-1:0]          outstanding_reg;
   logic                      error_reg;
   logic                      awvalid_reg;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_reg;
   logic [AXI_LEN_WIDTH-1:0]  awlen_reg;
   logic                      done_reg;
   logic                      cfg_hs;
   logic                      aw_hs;
   logic                      b_hs;

   assign cfg_ready   = (state_reg == S_IDLE);
   assign axi_bready  = (state_reg != S_IDLE);
   assign axi_awvalid = awvalid_reg;
   assign axi_awaddr  = awaddr_reg;
   assign axi_awlen   = awlen_reg;
   assign done        = done_reg;
   assign error       = error_reg;

   assign cfg_hs = cfg_valid & cfg_ready;
   assign aw_hs  = awvalid_reg & axi_awready;
   // A response with nothing outstanding is stale and is neither accepted nor counted.
   assign b_hs   = axi_bvalid & axi_bready & (outstanding_reg != '0);

   // Next burst size: whatever remains, capped at the largest AXI burst.
   always_comb begin
      burst_next = beats_rem_reg[BURST_W-1:0];
      if (beats_rem_reg > MAX_BURST)
         burst_next = MAX_BURST[BURST_W-1:0];
      awlen_next = burst_next - BURST_W'(1);
   end

   // Control FSM with registered AW channel and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         awvalid_reg <= 1'b0;
         awaddr_reg  <= '0;
         awlen_reg   <= '0;
         burst_reg   <= '0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (cfg_hs)
                  state_reg <= S_CONFIG;
            end
            S_CONFIG: begin
               burst_reg <= burst_next;
               if (beats_rem_reg == '0) begin
                  state_reg <= S_WAIT;
               end else begin
                  state_reg   <= S_ADDR;
                  awvalid_reg <= 1'b1;
                  awaddr_reg  <= addr_reg;
                  awlen_reg   <= awlen_next[AXI_LEN_WIDTH-1:0];
               end
            end
            S_ADDR: begin
               if (axi_awready) begin
                  awvalid_reg <= 1'b0;
                  state_reg   <= S_CONFIG;
               end
            end
            S_WAIT: begin
               // The last response arriving this cycle also completes the transfer.
               if ((outstanding_reg == '0) ||
                   ((outstanding_reg == OUT_W'(1)) && b_hs)) begin
                  state_reg <= S_DONE;
                  done_reg  <= 1'b1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg   <= S_IDLE;
               awvalid_reg <= 1'b0;
            end
         endcase
      end
   end

   // Address/beat counters, outstanding-response counter and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg        <= '0;
         beats_rem_reg   <= '0;
         outstanding_reg <= '0;
         error_reg       <= 1'b0;
      end else begin
         if (cfg_hs) begin
            addr_reg      <= AXI_ADDR_WIDTH'(cfg_address);
            beats_rem_reg <= cfg_length >> CONVERT_SHIFT;
            error_reg     <= 1'b0;
         end else if (aw_hs) begin
            beats_rem_reg <= beats_rem_reg - CONFIG_DWIDTH'(burst_reg);
            addr_reg      <= addr_reg + (AXI_ADDR_WIDTH'(burst_reg) << BYTE_SHIFT);
         end
         if (b_hs && (axi_bresp != 2'b00))
            error_reg <= 1'b1;
         case ({aw_hs, b_hs})
            2'b10:   outstanding_reg <= outstanding_reg + OUT_W'(1);
            2'b01:   outstanding_reg <= outstanding_reg - OUT_W'(1);
            default: outstanding_reg <= outstanding_reg;
         endcase
      end
   end

endmodule

// File: doc/axis_write_addr.md
AXIS_WRITE_ADDR -- requirements
Module: axis_write_addr

Interface
REQ-001 SHALL have parameter CONFIG_AWIDTH, default 32: width of the cfg_address port.
REQ-002 SHALL have parameter CONFIG_DWIDTH, default 32: width of cfg_length, counted in stream words.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32: AXI address width.
REQ-004 SHALL have parameter AXI_LEN_WIDTH, default 8: awlen width; the maximum burst is 2^AXI_LEN_WIDTH beats.
REQ-005 SHALL have parameter CONVERT_SHIFT, default 1: log2 of stream words per AXI beat.
REQ-006 SHALL have parameter BYTE_SHIFT, default 3: log2 of bytes per AXI beat.
REQ-007 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have ports cfg_address (input, CONFIG_AWIDTH): start byte address; cfg_length (input, CONFIG_DWIDTH): stream words; cfg_valid (input, 1); cfg_ready (output, 1).
REQ-010 SHALL have ports axi_awaddr (output, AXI_ADDR_WIDTH), axi_awlen (output, AXI_LEN_WIDTH), axi_awvalid (output, 1) and axi_awready (input, 1).
REQ-011 SHALL have ports axi_bresp (input, 2), axi_bvalid (input, 1) and axi_bready (output, 1).
REQ-012 SHALL have ports done (output, 1): one-cycle completion pulse; and error (output, 1): sticky non-OKAY response flag.

Function
REQ-013 SHALL implement a one-hot state machine with states IDLE, CONFIG, ADDR, WAIT and DONE; any illegal encoding goes to IDLE.
REQ-014 SHALL drive cfg_ready = IDLE; a config transfer is cfg_valid & cfg_ready.
REQ-015 On a config transfer it SHALL latch:
  - addr_reg = cfg_address, resized to AXI_ADDR_WIDTH;
  - beats_rem = cfg_length >> CONVERT_SHIFT (any remainder words are dropped);
  - error is cleared;
  - the state moves to CONFIG.
REQ-016 In CONFIG it SHALL compute burst_len = min(beats_rem, 2^AXI_LEN_WIDTH).
  - If beats_rem == 0 the next state is WAIT.
  - Otherwise the next state is ADDR, with axi_awaddr = addr_reg and axi_awlen = burst_len-1 registered.
REQ-017 In ADDR it SHALL hold axi_awvalid high with awaddr and awlen stable until axi_awready is sampled high.
REQ-018 On an AW handshake it SHALL update the counters:
  - beats_rem -= burst_len;
  - addr_reg += burst_len << BYTE_SHIFT, with modulo 2^AXI_ADDR_WIDTH wrap-around;
  - outstanding += 1;
  - the next state is CONFIG.
REQ-019 SHALL keep axi_awvalid registered and low in every state except ADDR.
REQ-020 SHALL assert axi_bready whenever the state is not IDLE; a B handshake decrements outstanding.
REQ-021 When an AW handshake and a B handshake occur in the same cycle, outstanding SHALL stay unchanged.
REQ-022 SHALL size outstanding at CONFIG_DWIDTH-AXI_LEN_WIDTH-CONVERT_SHIFT+1 bits, which can never overflow.
REQ-023 SHALL ignore and count nothing for a bvalid that arrives while outstanding == 0.
REQ-024 SHALL set error on any B handshake with axi_bresp != 2'b00; error holds until the next config transfer or rst.
REQ-025 In WAIT it SHALL move to DONE once outstanding == 0 and no B handshake is pending.
REQ-026 WAIT with outstanding == 1 and a B handshake in that cycle SHALL also move to DONE.
REQ-027 SHALL assert done for exactly the single DONE cycle; DONE always goes to IDLE.
REQ-028 SHALL hold cfg_ready low from CONFIG through DONE; cfg_valid in those states has no effect.
REQ-029 SHALL take 2 cycles from a config transfer to the first axi_awvalid, and 2 cycles between successive AW handshakes when awready is constantly high.

Reset
REQ-030 On rst the state SHALL become IDLE.
REQ-031 On rst SHALL clear axi_awvalid, done, error, outstanding, beats_rem and addr_reg to 0.
REQ-032 On rst SHALL clear axi_awaddr and axi_awlen to 0.
REQ-033 On rst SHALL set cfg_ready = 1 from the next cycle and drive axi_bready = 0.
REQ-034 Reset mid-operation SHALL abandon all bursts immediately.
REQ-035 After reset mid-operation, B responses for abandoned bursts SHALL not be accepted or counted.

Verification
REQ-036 Single burst: addr 0x1000, length 64, awready tied 1, B returned 3 cycles after AW -> exactly one AW, awaddr 0x1000, awlen 31; done pulses 1 cycle after the B handshake.
REQ-037 Multi-burst: addr 0x0, length 1100, default parameters -> bursts of 256, 256 and 38 beats; awaddr 0x0, 0x800, 0x1000; awlen 255, 255, 37; done follows the third B.
REQ-038 Backpressure: awready low for 10 cycles during the second burst -> awaddr and awlen stay stable while awvalid is high; no duplicate or lost burst.
REQ-039 Zero and odd length: length 0 -> no AW, done 3 cycles after config; length 3 -> one burst with awlen 0.
REQ-040 Error and simultaneous events: bresp 2'b10 on the second of 3 bursts, with one B coinciding with an AW handshake -> error = 1 at done, outstanding is correct, error clears on the next config.
REQ-041 Reset mid-stream: rst asserted in ADDR with 2 bursts outstanding -> awvalid is 0 and cfg_ready is 1 the cycle after; a new config runs cleanly.
